bf16_add_scheduler: RTL and testbench
=====================================

// Module: bf16_add_scheduler
// PURPOSE
//  Shares one multi-cycle bfloat16 adder among NREQ requesters. Round-robin
//  arbitration, operand capture, adder start/done sequencing, and a single
//  tagged response channel. Sits between the requesting datapaths and the adder.
// PARAMETERS
//  NREQ      4    number of requesters, 2..8
//  IDW       2    width of rsp_id, $clog2(NREQ)
//  MAX_WAIT  64   watchdog limit in cycles for adder completion (BF16_SCHED_TIMEOUT_EN only)
// PORTS
//  clock      in   1          system clock, rising edge
//  nreset     in   1          asynchronous active-low reset
//  req_valid  in   NREQ       requester i presents operands
//  req_ready  out  NREQ       one-hot accept strobe; transfer when valid&ready
//  req_a      in   NREQx16    operand A per requester, bf16
//  req_b      in   NREQx16    operand B per requester, bf16
//  add_a      out  16         operand A to the shared adder
//  add_b      out  16         operand B to the shared adder
//  add_start  out  1          one-cycle pulse launching the adder
//  add_done   in   1          adder completion strobe; add_sum valid this cycle
//  add_sum    in   16         adder result
//  rsp_valid  out  1          response available
//  rsp_ready  in   1          consumer accepts response
//  rsp_sum    out  16         result, bf16
//  rsp_id     out  IDW        index of the originating requester
//  rsp_err    out  1          watchdog expiry flag; constant 0 without the macro
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, all outputs 0 (req_ready, add_start, rsp_valid,
//    rsp_err deasserted; add_a/add_b/rsp_sum/rsp_id = 0). Reset mid-operation aborts
//    the transaction; a late add_done after reset release is ignored in IDLE.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
//    req_ready[grant] = 1 combinationally in the same cycle; on that edge capture req_a/b
//    into add_a/add_b, capture id, ptr <= (grant+1) mod NREQ, go ISSUE. No valid: stay.
//  - ISSUE: add_start = 1 for exactly one cycle; go WAIT. add_a/add_b held stable
//    from ISSUE until leaving WAIT.
//  - WAIT: add_done sampled only here; add_done in the ISSUE cycle is ignored.
//    On add_done: rsp_sum <= add_sum, go RESP.
//  - RESP: rsp_valid = 1; rsp_sum/rsp_id/rsp_err stable until rsp_ready. On
//    rsp_valid&rsp_ready go IDLE. No requests accepted in ISSUE/WAIT/RESP.
//  - Latency: accept at cycle T, add_start at T+1, done at D >= T+2, rsp_valid at D+1.
//    Minimum cycles between accepts: 4 (adder 1-cycle, rsp_ready held high).
//  - Fairness: a continuously valid requester is served within NREQ grants.
//  - Requester dropping req_valid before grant is legal; no state is retained.
//  - No arithmetic on operands: zero, NaN and infinity are passed through untouched.
// CONFIGURATION
//  - BF16_SCHED_TIMEOUT_EN defined: WAIT counts cycles; when count reaches MAX_WAIT
//    without add_done -> rsp_sum = BF16_QNAN (16'h7FC0), rsp_err = 1, go RESP.
//    Counter cleared on WAIT entry. add_done in the expiry cycle wins (normal result).
//  - Undefined: no counter; WAIT waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  - bf16_pkg: typedef logic [15:0] bf16_t; sched_state_t enum {IDLE, ISSUE, WAIT,
//    RESP}; localparam bf16_t BF16_QNAN = 16'h7FC0.
//  - Sub-module rr_arbiter (NREQ): req vector + ptr in, one-hot grant + index out,
//    purely combinational. Pointer register, FSM and capture registers stay in top.
// TESTING
//  - Single request: req_valid=4'b0001, a=16'h3F80, b=16'h3F80 -> add_start one cycle
//    after accept; rsp_sum=16'h4000, rsp_id=0, rsp_err=0.
//  - All four valid continuously, ptr=0 -> grant order 0,1,2,3,0; each rsp_id matches.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_sum, rsp_id held; req_ready=0.
//  - Spurious add_done in ISSUE cycle, true done 3 cycles later -> only second captured.
//  - nreset pulsed during WAIT -> all outputs 0, ptr 0; next request served normally.
//  - With BF16_SCHED_TIMEOUT_EN, MAX_WAIT=8, add_done never asserted -> after 8 WAIT
//    cycles rsp_valid=1, rsp_sum=16'h7FC0, rsp_err=1; without the macro rsp_valid stays 0.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared types and constants for the bfloat16 adder scheduler.
package bf16_pkg;
  typedef logic [15:0] bf16_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  localparam bf16_t BF16_QNAN = 16'h7FC0;
endpackage

// File: rtl/bf16_add_scheduler_if.sv
// Bus bundle between requesters, the shared adder, the response consumer and
// the scheduler. The scheduler uses the slave modport; the environment uses master.
interface bf16_add_scheduler_if
  import bf16_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  bf16_t [NREQ-1:0]  req_a;
  bf16_t [NREQ-1:0]  req_b;
  bf16_t             add_a;
  bf16_t             add_b;
  logic              add_start;
  logic              add_done;
  bf16_t             add_sum;
  logic              rsp_valid;
  logic              rsp_ready;
  bf16_t             rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, add_done, add_sum, rsp_ready,
    output req_ready, add_a, add_b, add_start, rsp_valid, rsp_sum, rsp_id, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, add_done, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, add_start, rsp_valid, rsp_sum, rsp_id, rsp_err
  );
endinterface

// File: rtl/bf16_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);
  logic [IDW-1:0] sel;

  // Scan ptr, ptr+1, ... modulo NREQ and take the first active request
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sel       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sel = IDW'((32'(ptr) + k) % NREQ);
      if (!any && req[sel]) begin
        any       = 1'b1;
        grant[sel] = 1'b1;
        grant_idx = sel;
      end
    end
  end
endmodule

// File: rtl/bf16_add_scheduler.sv
// Shares one multi-cycle bf16 adder among NREQ requesters with round-robin
// arbitration and a single tagged response channel.
// Optional feature: define BF16_SCHED_TIMEOUT_EN to enable the WAIT watchdog.
module bf16_add_scheduler
  import bf16_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned MAX_WAIT = 64
) (
  input logic                 clock,
  input logic                 nreset,
  bf16_add_scheduler_if.slave bus
);
  sched_state_t    state, state_next;
  logic [IDW-1:0]  ptr, id, grant_idx;
  logic [NREQ-1:0] grant;
  logic            any;
  bf16_t           op_a, op_b, sum;
  logic            timeout;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

`ifdef BF16_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  logic          err;

  // WAIT cycle counter; held at zero outside WAIT so every entry starts fresh
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)           cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
    else                   cnt <= '0;
  end

  assign timeout     = (state == WAIT) && (cnt == CW'(MAX_WAIT - 1));
  assign bus.rsp_err = err;
`else
  assign timeout     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; add_done takes priority over an expiring watchdog
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.add_done || timeout) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.req_ready = (state == IDLE) ? grant : '0;
    bus.add_start = (state == ISSUE);
    bus.rsp_valid = (state == RESP);
  end

  // Operand capture, pointer advance and result capture
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ptr  <= '0;
      id   <= '0;
      op_a <= '0;
      op_b <= '0;
      sum  <= '0;
`ifdef BF16_SCHED_TIMEOUT_EN
      err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any) begin
          op_a <= bus.req_a[grant_idx];
          op_b <= bus.req_b[grant_idx];
          id   <= grant_idx;
          ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef BF16_SCHED_TIMEOUT_EN
          err  <= 1'b0;
`endif
        end
        WAIT: if (bus.add_done) begin
          sum <= bus.add_sum;
        end
`ifdef BF16_SCHED_TIMEOUT_EN
        else if (timeout) begin
          sum <= BF16_QNAN;
          err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.add_a   = op_a;
  assign bus.add_b   = op_b;
  assign bus.rsp_sum = sum;
  assign bus.rsp_id  = id;
endmodule

// File: tb/tb_bf16_add_scheduler.sv
// Self-checking bench for bf16_add_scheduler: directed scenarios followed by
// randomized transactions against a behavioural round-robin/adder model.
module tb_bf16_add_scheduler;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned IDW      = 2;
  localparam int unsigned MAX_WAIT = 8;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int unsigned mptr = 0;

  always #5 clock = ~clock;

  bf16_add_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  bf16_add_scheduler #(
    .NREQ     (NREQ),
    .IDW      (IDW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in for the shared adder: the scheduler only forwards its output
  function automatic logic [15:0] adder_model(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3F80 && b == 16'h3F80) return 16'h4000;
    return {a[7:0], b[7:0]} ^ 16'h5A5A;
  endfunction

  // Reference arbitration: first valid requester starting at the model pointer
  function automatic int unsigned ref_grant(input logic [NREQ-1:0] v, input int unsigned p);
    for (int unsigned k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return NREQ;
  endfunction

  task automatic randomize_operands();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i] = 16'($urandom);
      bus.req_b[i] = 16'($urandom);
    end
  endtask

  // One full transaction, starting at a negedge with requests already driven
  task automatic do_txn(input int done_lat, input int bp, input bit spurious);
    int unsigned g;
    logic [15:0] ea, eb, es;
    #1;
    g = ref_grant(bus.req_valid, mptr);
    chk("req_ready_grant", 32'(bus.req_ready), 32'(1 << g));
    ea = bus.req_a[g];
    eb = bus.req_b[g];
    es = adder_model(ea, eb);
    @(negedge clock);
    mptr = (g + 1) % NREQ;
    chk("issue_add_start", 32'(bus.add_start), 1);
    chk("issue_add_a", 32'(bus.add_a), 32'(ea));
    chk("issue_add_b", 32'(bus.add_b), 32'(eb));
    chk("issue_req_ready", 32'(bus.req_ready), 0);
    if (spurious) begin
      bus.add_done = 1'b1;
      bus.add_sum  = ~es;
    end
    @(negedge clock);
    bus.add_done = 1'b0;
    chk("wait_add_start", 32'(bus.add_start), 0);
    for (int i = 1; i < done_lat; i++) begin
      chk("wait_no_rsp", 32'(bus.rsp_valid), 0);
      chk("wait_hold_a", 32'(bus.add_a), 32'(ea));
      chk("wait_hold_b", 32'(bus.add_b), 32'(eb));
      @(negedge clock);
    end
    bus.add_done = 1'b1;
    bus.add_sum  = es;
    @(negedge clock);
    bus.add_done = 1'b0;
    bus.add_sum  = 16'($urandom);
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_sum", 32'(bus.rsp_sum), 32'(es));
    chk("rsp_id", 32'(bus.rsp_id), g);
    chk("rsp_err", 32'(bus.rsp_err), 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp_sum", 32'(bus.rsp_sum), 32'(es));
      chk("bp_rsp_id", 32'(bus.rsp_id), g);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("rsp_released", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #400000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.add_done  = 1'b0;
    bus.add_sum   = '0;
    bus.rsp_ready = 1'b0;
    randomize_operands();

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_add_start", 32'(bus.add_start), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_add_a", 32'(bus.add_a), 0);
    chk("rst_add_b", 32'(bus.add_b), 0);
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    nreset = 1'b1;
    @(negedge clock);

    // Fairness: all requesters valid, pointer at 0 -> 0,1,2,3,0
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      randomize_operands();
      #1;
      chk("fair_order", 32'(bus.req_ready), 32'(1 << (i % 4)));
      do_txn(1, 0, 1'b0);
    end

    // Single request 1.0 + 1.0
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 16'h3F80;
    bus.req_b[0]  = 16'h3F80;
    do_txn(1, 0, 1'b0);

    // Backpressure with all requesters pending
    bus.req_valid = 4'b1111;
    randomize_operands();
    do_txn(2, 5, 1'b0);

    // Spurious done in ISSUE, true done three cycles later
    bus.req_valid = 4'b0100;
    do_txn(3, 0, 1'b1);

    // Special operands pass through untouched
    bus.req_valid = 4'b1000;
    bus.req_a[3]  = 16'h7FC1;
    bus.req_b[3]  = 16'hFF80;
    do_txn(1, 1, 1'b0);
    bus.req_valid = 4'b0010;
    bus.req_a[1]  = 16'h0000;
    bus.req_b[1]  = 16'h8000;
    do_txn(2, 0, 1'b0);

    // Reset during WAIT, then a late add_done in IDLE
    bus.req_valid = 4'b0100;
    #1;
    chk("rstw_grant", 32'(bus.req_ready), 32'b0100);
    @(negedge clock);
    @(negedge clock);
    bus.req_valid = '0;
    nreset = 1'b0;
    #1;
    chk("rstw_req_ready", 32'(bus.req_ready), 0);
    chk("rstw_add_start", 32'(bus.add_start), 0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rstw_add_a", 32'(bus.add_a), 0);
    chk("rstw_add_b", 32'(bus.add_b), 0);
    chk("rstw_rsp_id", 32'(bus.rsp_id), 0);
    @(negedge clock);
    nreset       = 1'b1;
    bus.add_done = 1'b1;
    bus.add_sum  = 16'h1234;
    @(negedge clock);
    bus.add_done = 1'b0;
    chk("late_done_rsp", 32'(bus.rsp_valid), 0);
    chk("late_done_start", 32'(bus.add_start), 0);
    mptr = 0;
    bus.req_valid = 4'b1010;
    randomize_operands();
    do_txn(2, 1, 1'b0);

    // Watchdog behaviour with no add_done
    bus.req_valid = 4'b0001;
    randomize_operands();
    #1;
    chk("to_grant", 32'(bus.req_ready), 32'(1 << ref_grant(bus.req_valid, mptr)));
    @(negedge clock);
    mptr = 1;
    bus.req_valid = '0;
    @(negedge clock);
`ifdef BF16_SCHED_TIMEOUT_EN
    for (int i = 0; i < MAX_WAIT; i++) begin
      chk("to_pending", 32'(bus.rsp_valid), 0);
      @(negedge clock);
    end
    chk("to_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("to_rsp_sum", 32'(bus.rsp_sum), 32'h7FC0);
    chk("to_rsp_err", 32'(bus.rsp_err), 1);
    chk("to_rsp_id", 32'(bus.rsp_id), 0);
`else
    for (int i = 0; i < 3 * MAX_WAIT; i++) begin
      chk("no_to_pending", 32'(bus.rsp_valid), 0);
      chk("no_to_err", 32'(bus.rsp_err), 0);
      @(negedge clock);
    end
    bus.add_done = 1'b1;
    bus.add_sum  = 16'hBEEF;
    @(negedge clock);
    bus.add_done = 1'b0;
    chk("no_to_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("no_to_rsp_sum", 32'(bus.rsp_sum), 32'hBEEF);
`endif
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("to_released", 32'(bus.rsp_valid), 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      bus.req_valid = 4'($urandom);
      randomize_operands();
      if (bus.req_valid == '0) begin
        #1;
        chk("idle_no_ready", 32'(bus.req_ready), 0);
        @(negedge clock);
        chk("idle_no_start", 32'(bus.add_start), 0);
        chk("idle_no_rsp", 32'(bus.rsp_valid), 0);
      end else begin
        do_txn(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
